// File: rtl/push_arbiter.sv
// rtl/push_arbiter.sv - first-press arbiter with synchronisers, debounce and round FSM (optional PUSH_ARBITER_RR_TIE_EN)
module push_arbiter #(
    parameter int NUM_PLAYERS     = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDX_W           = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] btn,
    input  logic                   clear,
    output logic                   armed,
    output logic                   push,
    output logic                   tie,
    output logic [IDX_W-1:0]       winner,
    output logic [NUM_PLAYERS-1:0] winner_oh
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_RELEASE,
        S_ARMED,
        S_CAPTURED
    } state_t;

    state_t                 state;
    logic [NUM_PLAYERS-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0]       cnt    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] s;
    logic [NUM_PLAYERS-1:0] db;
    logic [NUM_PLAYERS-1:0] db_q;
    logic [NUM_PLAYERS-1:0] pe_q;
    logic                   sync_ready;
    logic                   sync_idle;
    logic                   multi;
    logic [IDX_W-1:0]       lo_idx;
    logic [IDX_W-1:0]       pick;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // pe is registered once so a clean press lands SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after sampling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
            db         <= '0;
            db_q       <= '0;
            pe_q       <= '0;
            sync_ready <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            db_q       <= db;
            pe_q       <= db & ~db_q;
            sync_ready <= 1'b1;
        end
    end

    // A button still held after reset is visible in the first sync stage one edge later, so arming waits for it
    always_comb begin
        sync_idle = sync_ready;
        for (int k = 0; k < SYNC_STAGES; k++) begin
            if (|sync_q[k]) sync_idle = 1'b0;
        end
    end

    always_comb begin
        lo_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (pe_q[i]) lo_idx = IDX_W'(i);
        end
    end

    assign multi = |(pe_q & (pe_q - 1'b1));

`ifdef PUSH_ARBITER_RR_TIE_EN
    logic [IDX_W-1:0]         rr_ptr;
    logic [2*NUM_PLAYERS-1:0] pe_dbl;
    logic [NUM_PLAYERS-1:0]   pe_rot;
    logic [IDX_W-1:0]         rot_off;
    logic [IDX_W:0]           rr_sum;

    always_comb begin
        pe_dbl  = {pe_q, pe_q} >> rr_ptr;
        pe_rot  = pe_dbl[NUM_PLAYERS-1:0];
        rot_off = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (pe_rot[i]) rot_off = IDX_W'(i);
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
        if (rr_sum >= (IDX_W+1)'(NUM_PLAYERS)) rr_sum = rr_sum - (IDX_W+1)'(NUM_PLAYERS);
        pick = multi ? rr_sum[IDX_W-1:0] : lo_idx;
    end
`else
    assign pick = lo_idx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_WAIT_RELEASE;
            armed     <= 1'b0;
            push      <= 1'b0;
            tie       <= 1'b0;
            winner    <= '0;
            winner_oh <= '0;
`ifdef PUSH_ARBITER_RR_TIE_EN
            rr_ptr    <= '0;
`endif
        end else if (clear) begin
            state     <= S_WAIT_RELEASE;
            armed     <= 1'b0;
            push      <= 1'b0;
            tie       <= 1'b0;
            winner    <= '0;
            winner_oh <= '0;
        end else begin
            case (state)
                S_WAIT_RELEASE: begin
                    if (sync_idle && db == '0 && db_q == '0) begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (|pe_q) begin
                        state     <= S_CAPTURED;
                        armed     <= 1'b0;
                        push      <= 1'b1;
                        tie       <= multi;
                        winner    <= pick;
                        winner_oh <= pe_q;
`ifdef PUSH_ARBITER_RR_TIE_EN
                        if (multi) rr_ptr <= (pick == IDX_W'(NUM_PLAYERS - 1)) ? '0 : pick + 1'b1;
`endif
                    end
                end
                S_CAPTURED: begin
                    state <= S_CAPTURED;
                end
                default: begin
                    state <= S_WAIT_RELEASE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_arbiter.sv
// tb/tb_push_arbiter.sv - self-checking bench for push_arbiter (2- and 4-player instances)
module tb_push_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] btn;

    logic       a2, p2, t2;
    logic [0:0] w2;
    logic [1:0] oh2;
    logic       a4, p4, t4;
    logic [1:0] w4;
    logic [3:0] oh4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] btn;
        logic       tie;
        logic [1:0] win;
        logic [1:0] win_rr;
    } vec_t;

    typedef struct {
        logic       tie;
        logic [1:0] win;
        logic [3:0] oh;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    push_arbiter #(.NUM_PLAYERS(2)) dut2 (
        .clk(clk), .rst(rst), .btn(btn[1:0]), .clear(clear),
        .armed(a2), .push(p2), .tie(t2), .winner(w2), .winner_oh(oh2)
    );

    push_arbiter #(.NUM_PLAYERS(4)) dut4 (
        .clk(clk), .rst(rst), .btn(btn), .clear(clear),
        .armed(a4), .push(p4), .tie(t4), .winner(w4), .winner_oh(oh4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input string name);
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (a4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_armed"}, a4, 1);
    endtask

    task automatic capture_check(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (p4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_push"}, p4, 1);
        check({name, "_sb_pending"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_tie"}, t4, e.tie);
            check({name, "_winner"}, w4, e.win);
            check({name, "_winner_oh"}, oh4, e.oh);
            check({name, "_armed_low"}, a4, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        exp_t e;

        vecs[0] = '{4'b0010, 1'b0, 2'd1, 2'd1};
        vecs[1] = '{4'b0001, 1'b0, 2'd0, 2'd0};
        vecs[2] = '{4'b1000, 1'b0, 2'd3, 2'd3};
        vecs[3] = '{4'b0011, 1'b1, 2'd0, 2'd0};
        vecs[4] = '{4'b0011, 1'b1, 2'd0, 2'd1};
        vecs[5] = '{4'b1100, 1'b1, 2'd2, 2'd2};
        vecs[6] = '{4'b1001, 1'b1, 2'd0, 2'd3};
        vecs[7] = '{4'b0110, 1'b1, 2'd1, 2'd1};
        vecs[8] = '{4'b1111, 1'b1, 2'd0, 2'd2};

        rst   = 1'b0;
        clear = 1'b0;
        btn   = 4'b0000;
        ticks(3);
        check("reset_armed", a4, 0);
        check("reset_push", p4, 0);
        check("reset_tie", t4, 0);
        check("reset_winner", w4, 0);
        check("reset_winner_oh", oh4, 0);
        check("reset_push2", p2, 0);

        rst = 1'b1;
        tick();
        check("wait_release_armed", a4, 0);
        tick();
        check("armed_after_reset", a4, 1);
        check("armed_after_reset2", a2, 1);
        check("armed_push", p4, 0);
        check("armed_winner_oh", oh4, 0);

        btn = 4'b0010;
        e = '{1'b0, 2'd1, 4'b0010};
        sb.push_back(e);
        ticks(7);
        check("latency_early4", p4, 0);
        check("latency_early2", p2, 0);
        tick();
        check("latency2_push", p2, 1);
        check("latency2_winner", w2, 1);
        check("latency2_winner_oh", oh2, 2'b10);
        check("latency2_tie", t2, 0);
        check("latency2_armed", a2, 0);
        capture_check("latency4");
        ticks(2);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_push", p4, 0);
        check("clear_winner_oh", oh4, 0);
        check("clear_winner", w4, 0);
        check("clear_armed", a4, 0);
        ticks(5);
        check("held_after_clear_armed", a4, 0);
        btn = 4'b0000;
        ticks(7);
        check("rearm_early", a4, 0);
        tick();
        check("rearm_latency", a4, 1);

        btn = 4'b0001;
        ticks(3);
        btn = 4'b0000;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (p4 !== 1'b0) seen++;
        end
        check("glitch_push", seen, 0);
        check("glitch_armed", a4, 1);

        for (int v = 0; v < 9; v++) begin
            arm($sformatf("vec%0d", v));
            btn = vecs[v].btn;
`ifdef PUSH_ARBITER_RR_TIE_EN
            e = '{vecs[v].tie, vecs[v].win_rr, vecs[v].btn};
`else
            e = '{vecs[v].tie, vecs[v].win, vecs[v].btn};
`endif
            sb.push_back(e);
            capture_check($sformatf("vec%0d", v));
            btn = 4'b0000;
        end

        arm("p4seq");
        btn = 4'b0100;
        e = '{1'b0, 2'd2, 4'b0100};
        sb.push_back(e);
        ticks(2);
        btn = 4'b1100;
        capture_check("p4seq");
        ticks(4);
        check("later_ignored_winner", w4, 2);
        check("later_ignored_winner_oh", oh4, 4'b0100);
        check("later_ignored_tie", t4, 0);

        rst = 1'b0;
        #1;
        check("async_rst_push", p4, 0);
        check("async_rst_winner", w4, 0);
        check("async_rst_winner_oh", oh4, 0);
        check("async_rst_tie", t4, 0);
        check("async_rst_armed", a4, 0);
        ticks(2);
        rst = 1'b1;
        ticks(12);
        check("held_through_reset_armed", a4, 0);
        check("held_through_reset_push", p4, 0);
        btn = 4'b0000;
        seen = 0;
        while (a4 !== 1'b1 && seen < 40) begin
            tick();
            seen++;
        end
        check("release_after_reset_armed", a4, 1);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/push_arbiter.md
Name: push_arbiter

Overview:
- Clocked, parametrised first-press arbiter for the tug-of-war game. Generalises the two-player combinational push/tie/right latch to NUM_PLAYERS buttons.
- Adds input synchronisation, per-button debounce, a round state machine, a winner index and re-arm gating.
- Sits between the raw push-button pads and the game score/position logic. One round yields exactly one result, which is held until the round is cleared.

Parameters:
- NUM_PLAYERS, 2: number of player buttons; legal range 2..16.
- SYNC_STAGES, 2: flip-flop stages per button synchroniser; minimum 2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change; minimum 1.
- IDX_W, $clog2(NUM_PLAYERS) with minimum 1: width of the winner index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  NUM_PLAYERS  raw asynchronous buttons, active-high, one per player; bit i = player i.
- clear  input  1  synchronous round clear, active-high.
- armed  output  1  round open; presses are accepted.
- push  output  1  a press has been captured this round.
- tie  output  1  two or more players captured on the same cycle.
- winner  output  IDX_W  index of the winning player; valid while push=1.
- winner_oh  output  NUM_PLAYERS  one-hot of the captured player(s).

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops, debounce counters and debounced levels go to 0.
  - State goes to WAIT_RELEASE.
  - Outputs: armed=0, push=0, tie=0, winner=0, winner_oh=0.
- Synchroniser: each btn bit passes through SYNC_STAGES flops, giving s[i].
- Debounce, per bit:
  - The counter increments while s[i] differs from db[i], and is zeroed whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s[i] still differs, db[i] toggles on the next edge and the counter returns to 0.
  - A one-cycle glitch never reaches db.
- Press event: pe[i] = db[i] & ~db_q[i], where db_q is db delayed one cycle.
- State WAIT_RELEASE:
  - armed=0; pe is ignored.
  - When db is all zero, go to ARMED on the next edge.
  - Consequence: a button held through clear or reset cannot win the next round.
- State ARMED:
  - armed=1.
  - On the first cycle with pe non-zero, go to CAPTURED and register winner_oh=pe and push=1.
  - If exactly one bit of pe is set: tie=0 and winner = index of that bit.
  - If two or more bits are set: tie=1; winner = lowest set index, or as modified by the optional feature.
- State CAPTURED:
  - armed=0; all outputs held; later presses are ignored.
- clear:
  - In any state except reset, clear=1 forces state to WAIT_RELEASE on the next edge and zeroes push, tie, winner and winner_oh.
  - clear takes priority over a same-cycle pe in ARMED; that press is discarded.
- Latency: a clean press sampled high at edge 0 asserts push after edge L = SYNC_STAGES + DEBOUNCE_CYCLES + 1 (default 7).
- Press and release within DEBOUNCE_CYCLES: no event is generated.
- rst mid-round: outputs clear immediately (asynchronously). After rst release the block waits for all buttons to be released before arming.
- winner_oh is never non-zero while push=0.

Optional Feature:
- Macro: PUSH_ARBITER_RR_TIE_EN.
- When defined:
  - An IDX_W-bit rotating priority pointer resets to 0.
  - On a tie, winner = first set bit of pe at or after the pointer, searching upward with wrap-around.
  - After every tie capture, the pointer advances to winner+1, modulo NUM_PLAYERS.
  - tie is still asserted and winner_oh still shows all tied bits.
- When not defined: no pointer exists and ties resolve to the lowest set index.

Test Plan:
- Reset, then all buttons low for 3 cycles -> armed=1 and push=0 by cycle 2 after rst release (WAIT_RELEASE then ARMED), all other outputs 0.
- NUM_PLAYERS=2, btn=2'b10 held 10 cycles -> push=1 exactly 7 cycles after first sample; winner=1, winner_oh=2'b10, tie=0, armed=0.
- btn[0] pulsed high for 3 cycles only -> push stays 0 for 20 cycles (debounce rejection).
- btn=2'b11 raised on the same edge -> push=1, tie=1, winner_oh=2'b11, winner=0; with RR_TIE_EN, a second identical tie round gives winner=1.
- After a capture, assert clear while btn[1] is still held -> push=0 next cycle, armed stays 0. Release btn[1] -> armed=1 DEBOUNCE_CYCLES+SYNC_STAGES+1 cycles later.
- NUM_PLAYERS=4, btn[2] then btn[3] 2 cycles later; then assert rst mid-CAPTURED -> winner=2 and the later press is ignored; rst forces all outputs to 0 within the same cycle.
